prf_read_stage: RTL and testbench



---
 rtl/prf_pkg.sv | 11 +
 rtl/prf_bank.sv | 37 +++
 rtl/prf_read_stage.sv | 87 ++++++++
 tb/tb_prf_read_stage.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/prf_pkg.sv
// Shared sizing and type definitions for the physical register file read path.
package prf_pkg;

  localparam int unsigned NUM_REGS = 64;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned TAG_W    = $clog2(NUM_REGS);

  typedef logic [TAG_W-1:0]  preg_tag_t;
  typedef logic [DATA_W-1:0] preg_data_t;

endpackage

// File: rtl/prf_bank.sv
// Physical register storage: one write port, two combinational read ports.
// Tag 0 reads as zero and is never written.
import prf_pkg::*;

module prf_bank #(
  parameter int unsigned NUM_REGS = prf_pkg::NUM_REGS,
  parameter int unsigned DATA_W   = prf_pkg::DATA_W,
  parameter int unsigned TAG_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [TAG_W-1:0]  wrTag,
  input  logic [DATA_W-1:0] wrData,
  input  logic [TAG_W-1:0]  rdTag1,
  input  logic [TAG_W-1:0]  rdTag2,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2
);

  logic [DATA_W-1:0] regsQ [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regsQ[i] <= '0;
      end
    end else if (wrEn && (wrTag != '0)) begin
      regsQ[wrTag] <= wrData;
    end
  end

  // Entry 0 is forced on read so it stays zero even if its storage is disturbed.
  assign rdData1 = (rdTag1 == '0) ? '0 : regsQ[rdTag1];
  assign rdData2 = (rdTag2 == '0) ? '0 : regsQ[rdTag2];

endmodule

// File: rtl/prf_read_stage.sv
// Register-read pipeline stage: writeback bypass in front of the bank and a
// single registered output slot with valid/ready handshake.
import prf_pkg::*;

module prf_read_stage #(
  parameter int unsigned NUM_REGS = prf_pkg::NUM_REGS,
  parameter int unsigned DATA_W   = prf_pkg::DATA_W,
  parameter int unsigned TAG_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  rs1_tag,
  input  logic [TAG_W-1:0]  rs2_tag,
  input  logic              wb_en,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  logic [DATA_W-1:0] bankData1, bankData2;
  logic [DATA_W-1:0] opnd1, opnd2;
  logic              accept;
  logic              validQ, validD;
  logic [DATA_W-1:0] data1Q, data1D, data2Q, data2D;

  prf_bank #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .TAG_W    (TAG_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wrEn    (wb_en),
    .wrTag   (wb_tag),
    .wrData  (wb_data),
    .rdTag1  (rs1_tag),
    .rdTag2  (rs2_tag),
    .rdData1 (bankData1),
    .rdData2 (bankData2)
  );

  assign in_ready = !validQ || out_ready;
  assign accept   = in_valid && in_ready;

  // Bypass a same-cycle writeback; tag 0 never bypasses.
  always_comb begin
    opnd1 = bankData1;
    opnd2 = bankData2;
    if (wb_en && (wb_tag != '0) && (wb_tag == rs1_tag)) opnd1 = wb_data;
    if (wb_en && (wb_tag != '0) && (wb_tag == rs2_tag)) opnd2 = wb_data;
  end

  always_comb begin
    validD = validQ;
    data1D = data1Q;
    data2D = data2Q;
    if (accept) begin
      validD = 1'b1;
      data1D = opnd1;
      data2D = opnd2;
    end else if (validQ && out_ready) begin
      validD = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      validQ <= 1'b0;
      data1Q <= '0;
      data2Q <= '0;
    end else begin
      validQ <= validD;
      data1Q <= data1D;
      data2Q <= data2D;
    end
  end

  assign out_valid = validQ;
  assign rs1_data  = data1Q;
  assign rs2_data  = data2Q;

endmodule

// File: tb/tb_prf_read_stage.sv
// Self-checking bench for prf_read_stage: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_prf_read_stage;
  import prf_pkg::*;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, wb_en, out_valid, out_ready;
  preg_tag_t  rs1_tag, rs2_tag, wb_tag;
  preg_data_t wb_data, rs1_data, rs2_data;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: register contents and the output slot.
  preg_data_t mem [NUM_REGS];
  logic       mValid = 1'bx;
  preg_data_t m1 = 'x, m2 = 'x;

  always #5 clk = ~clk;

  prf_read_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1_tag   (rs1_tag),
    .rs2_tag   (rs2_tag),
    .wb_en     (wb_en),
    .wb_tag    (wb_tag),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic preg_data_t operand(input preg_tag_t t);
    if (t == 0) return '0;
    if (wb_en && wb_tag == t) return wb_data;
    return mem[t];
  endfunction

  // Check in_ready before the edge, advance the model across the edge, check outputs after.
  task automatic cycle();
    logic       rdy, nValid;
    preg_data_t n1, n2;
    rdy = !mValid || out_ready;
    if (!$isunknown(mValid)) checkVal("in_ready", 64'(in_ready), 64'(rdy));
    nValid = mValid;
    n1 = m1;
    n2 = m2;
    if (reset) begin
      nValid = 1'b0;
      n1 = '0;
      n2 = '0;
    end else if (in_valid && rdy) begin
      nValid = 1'b1;
      n1 = operand(rs1_tag);
      n2 = operand(rs2_tag);
    end else if (mValid && out_ready) begin
      nValid = 1'b0;
    end
    @(posedge clk);
    if (reset) begin
      foreach (mem[i]) mem[i] = '0;
    end else if (wb_en && wb_tag != 0) begin
      mem[wb_tag] = wb_data;
    end
    mValid = nValid;
    m1 = n1;
    m2 = n2;
    #1;
    checkVal("out_valid", 64'(out_valid), 64'(mValid));
    checkVal("rs1_data", rs1_data, m1);
    checkVal("rs2_data", rs2_data, m2);
  endtask

  task automatic drive(input logic rst, input logic iv, input int r1, input int r2,
                       input logic we, input int wt, input logic [63:0] wd,
                       input logic ordy);
    reset     = rst;
    in_valid  = iv;
    rs1_tag   = preg_tag_t'(r1);
    rs2_tag   = preg_tag_t'(r2);
    wb_en     = we;
    wb_tag    = preg_tag_t'(wt);
    wb_data   = wd;
    out_ready = ordy;
    #1;
    cycle();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; rs1_tag = '0; rs2_tag = '0;
    wb_en = 1'b0; wb_tag = '0; wb_data = '0; out_ready = 1'b1;
    #1;

    // Reset then read
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    checkVal("reset_valid", 64'(out_valid), 64'd0);
    drive(0, 1, 5, 0, 0, 0, 0, 1);
    checkVal("first_read", rs1_data, 64'd0);

    // Write then read through the array
    drive(0, 0, 0, 0, 1, 7, 64'hDEAD, 1);
    drive(0, 1, 7, 0, 0, 0, 0, 1);
    checkVal("wr_then_rd", rs1_data, 64'hDEAD);

    // Same-cycle bypass to both sources
    drive(0, 1, 9, 9, 1, 9, 64'h1234, 1);
    checkVal("bypass_rs1", rs1_data, 64'h1234);
    checkVal("bypass_rs2", rs2_data, 64'h1234);

    // Tag 0 write dropped, also under bypass
    drive(0, 1, 0, 0, 1, 0, 64'hFF, 1);
    checkVal("tag0_bypass", rs1_data, 64'd0);
    drive(0, 1, 0, 0, 0, 0, 0, 1);
    checkVal("tag0_read", rs2_data, 64'd0);

    // Stall hold while the held source is rewritten
    drive(0, 0, 0, 0, 1, 3, 64'hA, 1);
    drive(0, 1, 3, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 3, 3, 1, 3, 64'hB, 0);
      checkVal("hold_data", rs1_data, 64'hA);
      checkVal("hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    wb_en     = 1'b0;
    #1;
    checkVal("release_ready", 64'(in_ready), 64'd1);
    cycle();

    // Streaming: 8 back-to-back accepts, then drain
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, i, 9 - i, 1, i, 64'(i * 16), 1);
      checkVal("stream_valid", 64'(out_valid), 64'd1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    checkVal("drain_valid", 64'(out_valid), 64'd0);

    // Reset while holding a valid slot
    drive(0, 1, 7, 7, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    checkVal("rst_hold_valid", 64'(out_valid), 64'd0);
    drive(0, 1, 7, 0, 0, 0, 0, 1);
    checkVal("rst_cleared", rs1_data, 64'd0);

    // Random traffic over a small tag range to force collisions
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)),
            {$urandom, $urandom}, ($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
